// File: rtl/camera_tracker.sv
// Camera tracker: maps the character's world y to a screen index
// by repeated subtraction, and commits a new screen after it persists.
module camera_tracker #(
    parameter int PHY_WIDTH    = 14,
    parameter int BLOCK_WIDTH  = 480,
    parameter int CHAR_WIDTH_Y = 32,
    parameter int MAX_SCREEN   = 31,
    parameter int HOLD_FRAMES  = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 frame_start,
    input  logic [PHY_WIDTH-1:0] char_abs_y,
    output logic [4:0]           camera_y,
    output logic [PHY_WIDTH-1:0] camera_offset,
    output logic                 cam_change,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        CHECK
    } state_t;

    localparam logic [PHY_WIDTH:0] HALF_W =
        (PHY_WIDTH+1)'(CHAR_WIDTH_Y / 2);
    localparam logic [PHY_WIDTH:0] BW_W =
        (PHY_WIDTH+1)'(BLOCK_WIDTH);
    localparam logic [PHY_WIDTH-1:0] BW_P =
        PHY_WIDTH'(BLOCK_WIDTH);
    localparam logic [4:0] MAX_Q  = 5'(MAX_SCREEN);
    localparam logic [3:0] HOLD_P = 4'(HOLD_FRAMES);

    state_t               state_q, state_d;
    logic [PHY_WIDTH:0]   rem_q, rem_d;
    logic [4:0]           quot_q, quot_d;
    logic [4:0]           pend_target_q, pend_target_d;
    logic [3:0]           hold_cnt_q, hold_cnt_d;
    logic [4:0]           cam_y_q, cam_y_d;
    logic [PHY_WIDTH-1:0] cam_off_q, cam_off_d;
    logic                 cam_chg_q, cam_chg_d;
    logic                 busy_q, busy_d;
    logic [PHY_WIDTH-1:0] off_w;

    // Constant multiply; the quotient is already bounded by MAX_SCREEN
    assign off_w = PHY_WIDTH'(quot_q) * BW_P;

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        quot_d        = quot_q;
        pend_target_d = pend_target_q;
        hold_cnt_d    = hold_cnt_q;
        cam_y_d       = cam_y_q;
        cam_off_d     = cam_off_q;
        cam_chg_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    rem_d   = {1'b0, char_abs_y} + HALF_W;
                    quot_d  = 5'd0;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (rem_q >= BW_W && quot_q < MAX_Q) begin
                    rem_d  = rem_q - BW_W;
                    quot_d = quot_q + 5'd1;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (quot_q == cam_y_q) begin
                    hold_cnt_d = 4'd0;
                end else begin
                    if (quot_q != pend_target_q) begin
                        pend_target_d = quot_q;
                        hold_cnt_d    = 4'd1;
                    end else if (hold_cnt_q != 4'hF) begin
                        hold_cnt_d = hold_cnt_q + 4'd1;
                    end
                    if (hold_cnt_d >= HOLD_P) begin
                        cam_y_d    = quot_q;
                        cam_off_d  = off_w;
                        hold_cnt_d = 4'd0;
                        cam_chg_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            quot_q        <= '0;
            pend_target_q <= '0;
            hold_cnt_q    <= '0;
            cam_y_q       <= '0;
            cam_off_q     <= '0;
            cam_chg_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            quot_q        <= quot_d;
            pend_target_q <= pend_target_d;
            hold_cnt_q    <= hold_cnt_d;
            cam_y_q       <= cam_y_d;
            cam_off_q     <= cam_off_d;
            cam_chg_q     <= cam_chg_d;
            busy_q        <= busy_d;
        end
    end

    assign camera_y      = cam_y_q;
    assign camera_offset = cam_off_q;
    assign cam_change    = cam_chg_q;
    assign busy          = busy_q;

endmodule
